// File: rtl/mmb_stream_master_if.sv
// rtl/mmb_stream_master_if.sv - MemoryMapped burst bus between a burst master and a slave
interface mmb_stream_master_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int BWIDTH = 8
);
  logic [AWIDTH-1:0] m_addr;
  logic [BWIDTH-1:0] m_bcnt;
  logic              m_wreq;
  logic [DWIDTH-1:0] m_wdat;
  logic              m_rreq;
  logic [DWIDTH-1:0] m_rdat;
  logic              m_rval;
  logic              m_busy;

  modport master (
    output m_addr, m_bcnt, m_wreq, m_wdat, m_rreq,
    input  m_rdat, m_rval, m_busy
  );

  modport slave (
    input  m_addr, m_bcnt, m_wreq, m_wdat, m_rreq,
    output m_rdat, m_rval, m_busy
  );
endinterface

// File: rtl/mmb_stream_master.sv
// rtl/mmb_stream_master.sv - MemoryMapped burst master splitting stream transfers into bursts
// Optional MMB_STREAM_MASTER_BOUNDARY_EN: bursts never cross a 2**BNDWIDTH-word boundary.
module mmb_stream_master #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 32,
  parameter int BWIDTH   = 8,
  parameter int LWIDTH   = 16,
  parameter int MAXBURST = 16,
  parameter int MAXPEND  = 32,
  parameter int BNDWIDTH = 6
) (
  input  logic              reset,
  input  logic              clk,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [LWIDTH-1:0] cmd_len,
  input  logic              cmd_wr,
  input  logic              cmd_val,
  output logic              cmd_rdy,
  output logic              done,
  input  logic [DWIDTH-1:0] wr_dat,
  input  logic              wr_val,
  output logic              wr_rdy,
  output logic [DWIDTH-1:0] rd_dat,
  output logic              rd_val,
  mmb_stream_master_if.master bus
);
  localparam int PWIDTH = $clog2(MAXPEND + 1);

`ifdef MMB_STREAM_MASTER_BOUNDARY_EN
  localparam bit BND_EN = 1'b1;
`else
  localparam bit BND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_REQ, RD_DRAIN} state_t;

  state_t            state, state_next;
  logic [AWIDTH-1:0] addr;
  logic [LWIDTH-1:0] remain;
  logic [BWIDTH-1:0] beat;
  logic [BWIDTH-1:0] blen;
  logic [PWIDTH-1:0] pend;
  logic              cmd_rdy_q;
  logic              done_q;
  logic              rd_val_q;
  logic [DWIDTH-1:0] rd_dat_q;

  logic              accept, wr_beat, wr_last, rd_take, fin, rd_ret, room_ok;
  logic [AWIDTH-1:0] addr_adv;
  logic [LWIDTH-1:0] remain_wr, remain_rd;

  function automatic logic [BWIDTH-1:0] calc_blen(input logic [AWIDTH-1:0] a,
                                                 input logic [LWIDTH-1:0] r);
    logic [31:0] n;
    logic [31:0] room;
    n    = (32'(r) < 32'(MAXBURST)) ? 32'(r) : 32'(MAXBURST);
    room = (32'd1 << BNDWIDTH) - 32'(a[BNDWIDTH-1:0]);
    if (BND_EN && (room < n)) n = room;
    return BWIDTH'(n);
  endfunction

  // addr always holds the start of the current (or next) burst, so it doubles as m_addr
  assign addr_adv  = addr + AWIDTH'(blen);
  assign remain_wr = remain - LWIDTH'(1);
  assign remain_rd = remain - LWIDTH'(blen);
  assign room_ok   = (32'(pend) + 32'(blen)) <= 32'(MAXPEND);
  assign rd_ret    = bus.m_rval && (pend != '0);

  assign cmd_rdy    = cmd_rdy_q;
  assign done       = done_q;
  assign rd_val     = rd_val_q;
  assign rd_dat     = rd_dat_q;
  assign bus.m_addr = addr;
  assign bus.m_bcnt = blen;
  assign bus.m_wdat = wr_dat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    wr_beat    = 1'b0;
    wr_last    = 1'b0;
    rd_take    = 1'b0;
    fin        = 1'b0;
    wr_rdy     = 1'b0;
    bus.m_wreq = 1'b0;
    bus.m_rreq = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_val && cmd_rdy_q) begin
          accept     = 1'b1;
          state_next = cmd_wr ? WR_BURST : RD_REQ;
        end
      end
      WR_BURST: begin
        bus.m_wreq = wr_val;
        wr_rdy     = ~bus.m_busy;
        if (wr_val && !bus.m_busy) begin
          wr_beat = 1'b1;
          if (beat == blen - 1'b1) begin
            wr_last = 1'b1;
            if (remain_wr == '0) begin
              fin        = 1'b1;
              state_next = IDLE;
            end
          end
        end
      end
      RD_REQ: begin
        // pend only falls between consumes, so once room_ok holds it stays true
        bus.m_rreq = room_ok;
        if (room_ok && !bus.m_busy) begin
          rd_take = 1'b1;
          if (remain_rd == '0) state_next = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (pend == '0) begin
          fin        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr      <= '0;
      remain    <= '0;
      beat      <= '0;
      blen      <= '0;
      pend      <= '0;
      cmd_rdy_q <= 1'b0;
      done_q    <= 1'b0;
      rd_val_q  <= 1'b0;
      rd_dat_q  <= '0;
    end else begin
      // held low through the done cycle so cmd_rdy rises one cycle after done
      cmd_rdy_q <= (state == IDLE) && !accept;
      done_q    <= fin;
      rd_val_q  <= rd_ret;
      if (rd_ret) rd_dat_q <= bus.m_rdat;
      pend <= pend + (rd_take ? PWIDTH'(blen) : PWIDTH'(0)) - PWIDTH'(rd_ret);

      if (accept) begin
        addr   <= cmd_addr;
        remain <= cmd_len;
        blen   <= calc_blen(cmd_addr, cmd_len);
        beat   <= '0;
      end

      if (wr_beat) begin
        remain <= remain_wr;
        if (wr_last) begin
          addr <= addr_adv;
          blen <= calc_blen(addr_adv, remain_wr);
          beat <= '0;
        end else begin
          beat <= beat + 1'b1;
        end
      end

      if (rd_take) begin
        addr   <= addr_adv;
        remain <= remain_rd;
        blen   <= calc_blen(addr_adv, remain_rd);
      end
    end
  end
endmodule

// File: tb/tb_mmb_stream_master.sv
// tb/tb_mmb_stream_master.sv - self-checking bench for mmb_stream_master
`timescale 1ns/1ps
module tb_mmb_stream_master;
  localparam int DW = 32, AW = 32, BW = 8, LW = 16, MAXB = 16, MAXP = 32, BNDW = 4;
`ifdef MMB_STREAM_MASTER_BOUNDARY_EN
  localparam bit BND = 1'b1;
`else
  localparam bit BND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_wr = 1'b0;
  logic          cmd_val = 1'b0;
  logic          cmd_rdy, done, wr_rdy, rd_val;
  logic [DW-1:0] wr_dat = '0;
  logic          wr_val = 1'b0;
  logic [DW-1:0] rd_dat;

  mmb_stream_master_if #(.DWIDTH(DW), .AWIDTH(AW), .BWIDTH(BW)) bus ();

  mmb_stream_master #(
    .DWIDTH(DW), .AWIDTH(AW), .BWIDTH(BW), .LWIDTH(LW),
    .MAXBURST(MAXB), .MAXPEND(MAXP), .BNDWIDTH(BNDW)
  ) dut (
    .reset(reset), .clk(clk),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wr(cmd_wr), .cmd_val(cmd_val),
    .cmd_rdy(cmd_rdy), .done(done),
    .wr_dat(wr_dat), .wr_val(wr_val), .wr_rdy(wr_rdy),
    .rd_dat(rd_dat), .rd_val(rd_val),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [BW-1:0] n; logic wr; } burst_t;
  typedef struct { int due; logic [DW-1:0] d; } ret_t;
  typedef struct { logic wr; logic [AW-1:0] a; int len; int bp; int gp; int lt;
                   int nb; int fbc; int lbc; int pmx; } vec_t;

  int nchk = 0, nerr = 0;
  int cyc = 0, busy_pct = 0, gap_pct = 0, lat = 2;
  int outst = 0, pmax = 0, viol = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0, wbeat = 0;
  logic rdy_at_done = 1'b0, rdy_after = 1'b0, done_prev = 1'b0, xfer_prev = 1'b0;
  logic p_req = 1'b0, p_busy = 1'b0, p_wreq = 1'b0, p_rreq = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [BW-1:0] p_bcnt = '0;
  logic [DW-1:0] p_wdat = '0;
  burst_t bursts[$];
  ret_t   ret_q[$];
  logic [DW-1:0] src_q[$], got_wr[$], got_rd[$];

  function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
    return a * 32'h9E37 + 32'h0123_4567;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // slave and write-stream source: drive just after each rising edge
  initial begin
    bus.m_busy = 1'b0; bus.m_rval = 1'b0; bus.m_rdat = '0;
    forever begin
      @(posedge clk); #1;
      bus.m_busy = ($urandom_range(99) < busy_pct);
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        bus.m_rval = 1'b1;
        bus.m_rdat = ret_q[0].d;
        void'(ret_q.pop_front());
      end else begin
        bus.m_rval = 1'b0;
        bus.m_rdat = $urandom;
      end
      if (xfer_prev) void'(src_q.pop_front());
      if (!wr_val || xfer_prev) begin
        if (src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
          wr_val = 1'b1; wr_dat = src_q[0];
        end else begin
          wr_val = 1'b0; wr_dat = $urandom;
        end
      end
    end
  end

  // bus monitor: samples mid-cycle, once combinational outputs have settled
  initial begin
    burst_t bt;
    ret_t   rt;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        p_req = 1'b0; wbeat = 0; xfer_prev = 1'b0; done_prev = 1'b0;
      end else begin
        if (bus.m_wreq && bus.m_rreq) viol++;
        if (p_req && p_busy && (bus.m_wreq !== p_wreq || bus.m_rreq !== p_rreq ||
            bus.m_addr !== p_addr || bus.m_bcnt !== p_bcnt || (p_wreq && bus.m_wdat !== p_wdat)))
          viol++;
        if (bus.m_rreq && wbeat != 0) viol++;
        if (bus.m_rval && outst > 0) outst--;
        if (bus.m_wreq && !bus.m_busy) begin
          if (wbeat == 0) begin
            bt.a = bus.m_addr; bt.n = bus.m_bcnt; bt.wr = 1'b1;
            bursts.push_back(bt);
          end else if (bus.m_addr !== bursts[bursts.size()-1].a ||
                       bus.m_bcnt !== bursts[bursts.size()-1].n) begin
            viol++;
          end
          got_wr.push_back(bus.m_wdat);
          last_cyc = cyc;
          wbeat++;
          if (wbeat >= int'(bus.m_bcnt)) wbeat = 0;
        end
        if (bus.m_rreq && !bus.m_busy) begin
          bt.a = bus.m_addr; bt.n = bus.m_bcnt; bt.wr = 1'b0;
          bursts.push_back(bt);
          for (int i = 0; i < int'(bus.m_bcnt); i++) begin
            rt.due = cyc + lat;
            rt.d   = rdata(bus.m_addr + AW'(i));
            ret_q.push_back(rt);
          end
          outst += int'(bus.m_bcnt);
        end
        if (outst > pmax) pmax = outst;
        if (rd_val) begin
          got_rd.push_back(rd_dat);
          last_cyc = cyc;
        end
        if (done_prev) rdy_after = cmd_rdy;
        if (done) begin
          done_cnt++; done_cyc = cyc; rdy_at_done = cmd_rdy;
        end
        done_prev = done;
        xfer_prev = wr_val && wr_rdy;
        p_req = bus.m_wreq || bus.m_rreq; p_busy = bus.m_busy;
        p_wreq = bus.m_wreq; p_rreq = bus.m_rreq;
        p_addr = bus.m_addr; p_bcnt = bus.m_bcnt; p_wdat = bus.m_wdat;
      end
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] a, input int len);
    int guard;
    @(posedge clk); #1;
    cmd_addr = a; cmd_len = LW'(len); cmd_wr = wr; cmd_val = 1'b1;
    guard = 0;
    do begin
      @(negedge clk); guard++;
    end while (!cmd_rdy && guard < 200);
    chk("cmd_accept", cmd_rdy, 1);
    @(posedge clk); #1;
    cmd_val = 1'b0;
  endtask

  task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input int len,
                         input int bp, input int gp, input int lt,
                         output int nb, output int fbc, output int lbc, output int pm);
    burst_t eb[$];
    burst_t bt;
    logic [DW-1:0] ew[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] w;
    logic [AW-1:0] ma;
    int r, b, room, guard, mism;
    bursts.delete(); got_wr.delete(); got_rd.delete();
    viol = 0; done_cnt = 0; pmax = 0;
    busy_pct = bp; gap_pct = gp; lat = lt;
    ma = a; r = len;
    while (r > 0) begin
      b = (r < MAXB) ? r : MAXB;
      room = (1 << BNDW) - int'(ma[BNDW-1:0]);
      if (BND && room < b) b = room;
      bt.a = ma; bt.n = BW'(b); bt.wr = wr;
      eb.push_back(bt);
      ma = ma + AW'(b);
      r = r - b;
    end
    for (int i = 0; i < len; i++) begin
      if (wr) begin
        w = $urandom; src_q.push_back(w); ew.push_back(w);
      end else begin
        ew.push_back(rdata(a + AW'(i)));
      end
    end
    issue(wr, a, len);
    guard = 0;
    while (done_cnt == 0 && guard < 2000) begin
      @(negedge clk); guard++;
    end
    repeat (6) @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("n_bursts", bursts.size(), eb.size());
    mism = 0;
    for (int i = 0; i < eb.size() && i < bursts.size(); i++)
      if (bursts[i].a !== eb[i].a || bursts[i].n !== eb[i].n || bursts[i].wr !== eb[i].wr) mism++;
    chk("burst_list", mism, 0);
    if (wr) got = got_wr; else got = got_rd;
    chk("data_count", got.size(), len);
    mism = 0;
    for (int i = 0; i < ew.size() && i < got.size(); i++)
      if (got[i] !== ew[i]) mism++;
    chk("data_order", mism, 0);
    chk("protocol", viol, 0);
    chk("done_timing", done_cyc, last_cyc + 1);
    chk("rdy_at_done", rdy_at_done, 0);
    chk("rdy_after_done", rdy_after, 1);
    chk("pend_bound", (pmax <= MAXP) ? 1 : 0, 1);
    chk("pend_idle", outst, 0);
    nb  = bursts.size();
    fbc = (bursts.size() > 0) ? int'(bursts[0].n) : -1;
    lbc = (bursts.size() > 0) ? int'(bursts[bursts.size()-1].n) : -1;
    pm  = pmax;
    src_q.delete();
  endtask

  vec_t vt[7];

  initial begin
    int nb, fbc, lbc, pm, guard;
    vt[0] = '{1'b1, 32'h100, 40, 0, 0, 2, 3, 16, 8, 0};
    vt[1] = '{1'b0, 32'h20, 5, 0, 0, 2, 1, 5, 5, 5};
    vt[2] = '{1'b0, 32'h1000, 64, 0, 0, 10, 4, 16, 16, 32};
`ifdef MMB_STREAM_MASTER_BOUNDARY_EN
    vt[3] = '{1'b1, 32'h0E, 20, 50, 30, 2, 3, 2, 2, 0};
    vt[4] = '{1'b1, 32'hFFFF_FFFC, 20, 30, 0, 2, 2, 4, 16, 0};
    vt[6] = '{1'b1, 32'h35, 40, 20, 20, 2, 3, 11, 13, 0};
`else
    vt[3] = '{1'b1, 32'h0E, 20, 50, 30, 2, 2, 16, 4, 0};
    vt[4] = '{1'b1, 32'hFFFF_FFFC, 20, 30, 0, 2, 2, 16, 4, 0};
    vt[6] = '{1'b1, 32'h35, 40, 20, 20, 2, 3, 16, 8, 0};
`endif
    vt[5] = '{1'b0, 32'h7, 1, 40, 0, 1, 1, 1, 1, 1};

    repeat (3) @(negedge clk);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_rdy", wr_rdy, 0);
    chk("rst_rd_val", rd_val, 0);
    chk("rst_wreq", bus.m_wreq, 0);
    chk("rst_rreq", bus.m_rreq, 0);
    chk("rst_addr", bus.m_addr, 0);
    chk("rst_bcnt", bus.m_bcnt, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); chk("rdy_before_edge", cmd_rdy, 0);
    @(negedge clk); chk("rdy_after_release", cmd_rdy, 1);

    for (int i = 0; i < 7; i++) begin
      run_cmd(vt[i].wr, vt[i].a, vt[i].len, vt[i].bp, vt[i].gp, vt[i].lt, nb, fbc, lbc, pm);
      chk("vec_nbursts", nb, vt[i].nb);
      chk("vec_first_bcnt", fbc, vt[i].fbc);
      chk("vec_last_bcnt", lbc, vt[i].lbc);
      chk("vec_pend_max", pm, vt[i].pmx);
    end

    for (int i = 0; i < 10; i++)
      run_cmd(1'($urandom_range(1)), $urandom, int'($urandom_range(70, 1)),
              int'($urandom_range(60)), int'($urandom_range(50)), int'($urandom_range(12, 1)),
              nb, fbc, lbc, pm);

    // reset with ten read words outstanding; stray returns must be dropped
    bursts.delete(); got_rd.delete(); busy_pct = 0; lat = 20;
    issue(1'b0, 32'h300, 10);
    guard = 0;
    while (outst != 10 && guard < 50) begin
      @(negedge clk); guard++;
    end
    chk("pend_before_reset", outst, 10);
    @(posedge clk); #1;
    reset = 1'b0; outst = 0; done_cnt = 0;
    @(negedge clk);
    chk("mid_rst_cmd_rdy", cmd_rdy, 0);
    chk("mid_rst_rreq", bus.m_rreq, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); chk("mid_rdy_before_edge", cmd_rdy, 0);
    @(negedge clk); chk("mid_rdy_after_release", cmd_rdy, 1);
    guard = 0;
    while (ret_q.size() > 0 && guard < 100) begin
      @(negedge clk); guard++;
    end
    repeat (4) @(negedge clk);
    chk("stray_drained", ret_q.size(), 0);
    chk("stray_rd_val", got_rd.size(), 0);
    chk("stray_done", done_cnt, 0);
    run_cmd(1'b0, 32'h40, 20, 20, 0, 3, nb, fbc, lbc, pm);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mmb_stream_master.md
Name: mmb_stream_master

Overview:
- Master (initiator) side of the MemoryMapped burst interface (m_addr/m_bcnt/m_wreq/m_wdat/m_rreq/m_rdat/m_rval/m_busy).
- Accepts one transfer command at a time: start word address, length in words, direction.
- Splits the transfer into bursts of at most MAXBURST words.
- Write: sources data from a valid/ready input stream. Read: delivers returned data on an output stream, bounding outstanding read words.
- Sits between DMA/stream logic and any MemoryMapped burst slave or interconnect.

Parameters:
- DWIDTH, 32, data width.
- AWIDTH, 32, word address width.
- BWIDTH, 8, m_bcnt width.
- LWIDTH, 16, command length width.
- MAXBURST, 16, max words per burst; 1 <= MAXBURST <= 2**BWIDTH-1.
- MAXPEND, 32, max outstanding read words; MAXPEND >= MAXBURST.
- BNDWIDTH, 6, burst boundary is 2**BNDWIDTH words; used only with the optional feature.

Ports:
- reset  in  1  asynchronous reset, active low.
- clk  in  1  clock.
- cmd_addr  in  AWIDTH  start word address.
- cmd_len  in  LWIDTH  length in words; 0 is illegal.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_val  in  1  command valid.
- cmd_rdy  out  1  command accepted when cmd_val & cmd_rdy.
- done  out  1  one-cycle pulse when a transfer completes.
- wr_dat  in  DWIDTH  write stream data.
- wr_val  in  1  write stream valid.
- wr_rdy  out  1  write stream ready.
- rd_dat  out  DWIDTH  read stream data.
- rd_val  out  1  read stream valid; no backpressure.
- m_addr  out  AWIDTH  burst start address.
- m_bcnt  out  BWIDTH  burst length.
- m_wreq  out  1  write request/beat.
- m_wdat  out  DWIDTH  write data.
- m_rreq  out  1  read request.
- m_rdat  in  DWIDTH  read data.
- m_rval  in  1  read data valid.
- m_busy  in  1  slave stall.

Behaviour:
- Reset (reset low, async): state IDLE, cmd_rdy=0, done=0, wr_rdy=0, rd_val=0, m_wreq=0, m_rreq=0, m_addr=0, m_bcnt=0, counters=0. cmd_rdy rises the first cycle after reset release.
- Protocol rules:
  - A request is consumed on a cycle with (m_wreq|m_rreq) & ~m_busy.
  - While m_busy, m_addr/m_bcnt/m_wdat/m_wreq/m_rreq stay stable.
  - m_wreq and m_rreq are never high together.
  - A write burst is exactly m_bcnt consumed wreq beats. m_addr/m_bcnt are significant on the first beat only but are held unchanged for the whole burst.
  - m_rreq is never asserted while a write burst is incomplete.
- Registers: addr (AWIDTH, wraps mod 2**AWIDTH), remain (LWIDTH), beat (BWIDTH), pend (read words outstanding, clog2(MAXPEND+1) bits).
- Burst length blen = min(remain, MAXBURST), registered when a burst starts.
- FSM:
  - IDLE: cmd_rdy=1. On accept, latch addr/remain and go to WR_BURST if cmd_wr, else RD_REQ.
  - WR_BURST:
    - Comb: m_wreq=wr_val; m_wdat=wr_dat; wr_rdy=~m_busy.
    - Each consumed beat: beat++, remain--. On the last beat of the burst, addr+=blen.
    - After the last beat: if remain==0, pulse done and go to IDLE; else start the next burst (new blen, beat=0) with no idle cycle.
    - wr_val low mid-burst pauses the burst; no other request is inserted.
  - RD_REQ:
    - m_rreq=1 only when pend+blen <= MAXPEND.
    - Once asserted, m_rreq stays high until consumed, even if pend changes.
    - On consume: pend+=blen, addr+=blen, remain-=blen. If remain==0, go to RD_DRAIN; else stay in RD_REQ and recompute blen.
  - RD_DRAIN: wait until pend==0, then pulse done and go to IDLE.
- Read return, in any state: rd_val=m_rval & (pend!=0), rd_dat=m_rdat, registered with 1-cycle latency; pend-- per valid beat.
  - Simultaneous consume and return on one cycle: pend = pend + blen - 1.
  - m_rval with pend==0 (e.g. stray data after a reset mid-transfer) is dropped silently.
- done is registered. cmd_rdy rises in the cycle after done.

Optional Feature:
- MMB_STREAM_MASTER_BOUNDARY_EN defined: blen = min(remain, MAXBURST, 2**BNDWIDTH - addr[BNDWIDTH-1:0]), so no burst crosses a 2**BNDWIDTH-word boundary.
- Undefined: blen = min(remain, MAXBURST) and BNDWIDTH is unused.

Test Plan:
- Write addr=0x100, len=40, MAXBURST=16, m_busy=0, wr_val=1 -> bursts (0x100,16), (0x110,16), (0x120,8); 40 contiguous wreq beats; done one cycle after beat 40.
- Read addr=0x20, len=5, slave latency 2 -> single m_rreq (0x20,5); 5 rd_val beats in order; done after the fifth; pend returns to 0.
- Read len=64, MAXPEND=32, slave delays data 10 cycles -> at most 2 bursts outstanding; third m_rreq only after pend<=16; 64 rd_val beats total.
- Random m_busy 50% plus wr_val gaps on write len=20 -> m_addr/m_bcnt/m_wdat stable under busy; no rreq; exactly 20 beats consumed; data order preserved.
- Reset low during read with pend=10, then release; slave still returns 10 beats -> rd_val stays 0, cmd_rdy=1 one cycle after release, next command runs normally.
- MMB_STREAM_MASTER_BOUNDARY_EN, BNDWIDTH=4, write addr=0x0E, len=20 -> bursts (0x0E,2), (0x10,16), (0x20,2).
